// File: rtl/bsg_wormhole_router_output_control_pkg.sv
// Shared types and helpers for the wormhole router output-port control.
package bsg_wormhole_router_output_control_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // Round-robin pointer width; a single input still needs one bit of storage.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_wormhole_router_rr_arb.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr, with wrap.
module bsg_wormhole_router_rr_arb
    import bsg_wormhole_router_output_control_pkg::*;
#(
    parameter int input_dirs_p = 2,
    parameter int ptr_w_p      = ptr_width(input_dirs_p)
) (
    input  logic [input_dirs_p-1:0] reqs,
    input  logic [ptr_w_p-1:0]      rr_ptr,
    output logic [input_dirs_p-1:0] grant
);

    logic [input_dirs_p-1:0] upper_mask;
    logic [input_dirs_p-1:0] upper_reqs;
    logic [input_dirs_p-1:0] pick;

    for (genvar i = 0; i < input_dirs_p; i++) begin : g_mask
        assign upper_mask[i] = (rr_ptr <= ptr_w_p'(i));
    end

    // Prefer requests at/above the pointer; otherwise wrap to the lowest index.
    assign upper_reqs = reqs & upper_mask;
    assign pick       = (|upper_reqs) ? upper_reqs : reqs;
    assign grant      = pick & (-pick);

endmodule

// File: rtl/bsg_wormhole_router_output_control.sv
// Output-port control: round-robin header arbitration, packet lock, crossbar select and yumi.
module bsg_wormhole_router_output_control
    import bsg_wormhole_router_output_control_pkg::*;
#(
    parameter int input_dirs_p = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [input_dirs_p-1:0] reqs_i,
    input  logic [input_dirs_p-1:0] release_i,
    input  logic [input_dirs_p-1:0] valid_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [input_dirs_p-1:0] data_sel_o,
    output logic [input_dirs_p-1:0] yumi_o
);

    localparam int PTR_W = ptr_width(input_dirs_p);

    lock_state_e             state_r, state_n;
    logic [input_dirs_p-1:0] grant_r, grant_n;
    logic [PTR_W-1:0]        rr_ptr_r, rr_ptr_n;

    logic [input_dirs_p-1:0] win;
    logic [input_dirs_p-1:0] sel;
    logic                    link_vld;
    logic                    xfer;
    logic                    sel_release;
    logic [PTR_W-1:0]        win_next_ptr;

    bsg_wormhole_router_rr_arb #(
        .input_dirs_p (input_dirs_p),
        .ptr_w_p      (PTR_W)
    ) rr_arb (
        .reqs   (reqs_i),
        .rr_ptr (rr_ptr_r),
        .grant  (win)
    );

    // Pointer that follows the one-hot winner, built as an OR chain of constants.
    logic [PTR_W-1:0] ptr_acc [input_dirs_p+1];
    assign ptr_acc[0] = '0;
    for (genvar i = 0; i < input_dirs_p; i++) begin : g_next_ptr
        assign ptr_acc[i+1] = ptr_acc[i] | (win[i] ? PTR_W'((i + 1) % input_dirs_p) : '0);
    end
    assign win_next_ptr = ptr_acc[input_dirs_p];

    assign sel         = (state_r == ST_LOCKED) ? grant_r : win;
    assign link_vld    = (state_r == ST_LOCKED) ? |(valid_i & grant_r) : |reqs_i;
    assign sel_release = |(release_i & sel);

    // Outputs are held quiet for the whole time reset is asserted, not just after the edge.
    assign xfer       = link_vld & ready_i & reset_n_i;
    assign valid_o    = link_vld & reset_n_i;
    assign data_sel_o = reset_n_i ? sel : '0;
    assign yumi_o     = xfer ? sel : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= ST_UNLOCKED;
            grant_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_n;
            grant_r  <= grant_n;
            rr_ptr_r <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n  = state_r;
        grant_n  = grant_r;
        rr_ptr_n = rr_ptr_r;
        unique case (state_r)
            ST_UNLOCKED: begin
                if (xfer) begin
                    rr_ptr_n = win_next_ptr;
                    // A header that is also the tail is a complete packet; no lock needed.
                    if (!sel_release) begin
                        state_n = ST_LOCKED;
                        grant_n = win;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_release) begin
                    state_n = ST_UNLOCKED;
                    grant_n = '0;
                end
            end
            default: begin
                state_n = ST_UNLOCKED;
                grant_n = '0;
            end
        endcase
    end

endmodule
